// File: rtl/snake_collision_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : snake_collision_scanner_if
// Purpose  : Bundles the movement-controller handshake, the latched move
//            operands, the result flags and the body-store read port of the
//            snake collision scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface snake_collision_scanner_if #(
  parameter int COORD_W = 4,
  parameter int LEN_W   = 8
);
  logic               start;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [LEN_W-1:0]   snake_length;
  logic [COORD_W-1:0] food_x;
  logic [COORD_W-1:0] food_y;
  logic [LEN_W-1:0]   rd_addr;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               busy;
  logic               done;
  logic               hit_self;
  logic               hit_wall;
  logic               hit_food;
  logic [LEN_W-1:0]   hit_index;

  // Controller plus body RAM side
  modport master (
    output start, head_x, head_y, snake_length, food_x, food_y, rd_x, rd_y,
    input  rd_addr, busy, done, hit_self, hit_wall, hit_food, hit_index
  );

  // Scanner side
  modport slave (
    input  start, head_x, head_y, snake_length, food_x, food_y, rd_x, rd_y,
    output rd_addr, busy, done, hit_self, hit_wall, hit_food, hit_index
  );
endinterface
`default_nettype wire

// File: rtl/snake_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : snake_collision_scanner
// Purpose  : Per-move collision check. Tests the new head against the grid
//            bounds and the food, then walks the body store one segment per
//            clock through a synchronous read port looking for a self hit.
// Revision : 1.0 - initial release
// ============================================================================
module snake_collision_scanner #(
  parameter int COORD_W    = 4,
  parameter int LEN_W      = 8,
  parameter int MAX_LEN    = 128,
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 16,
  parameter int EARLY_EXIT = 1
) (
  input  wire logic                clk,
  input  wire logic                rst,
  snake_collision_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_SCAN   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);

  state_t             r_state;
  state_t             w_next;

  logic [COORD_W-1:0] r_head_x;
  logic [COORD_W-1:0] r_head_y;
  logic [COORD_W-1:0] r_food_x;
  logic [COORD_W-1:0] r_food_y;
  logic [LEN_W-1:0]   r_len_eff;
  logic [LEN_W-1:0]   r_rd_addr;
  logic [LEN_W-1:0]   r_cmp_idx;   // index of the segment data currently on rd_x/rd_y
  logic               r_hit_self;
  logic               r_hit_wall;
  logic               r_hit_food;
  logic [LEN_W-1:0]   r_hit_index;

  logic [LEN_W-1:0]   w_in_len_eff;
  logic               w_in_skip;
  logic               w_wall;
  logic               w_short;
  logic               w_food;
  logic [LEN_W-1:0]   w_last;
  logic               w_match;
  logic               w_stop;
  logic [LEN_W-1:0]   w_addr_inc;

  // Acceptance-time view of the request: the first read address is launched
  // in the CHECK cycle, so whether a scan will happen is decided from the raw
  // inputs.
  assign w_in_len_eff = (bus.snake_length > c_max_len) ? c_max_len : bus.snake_length;
  assign w_in_skip    = (32'(bus.head_x) >= GRID_W) || (32'(bus.head_y) >= GRID_H) ||
                        (w_in_len_eff <= c_one);

  assign w_wall     = (32'(r_head_x) >= GRID_W) || (32'(r_head_y) >= GRID_H);
  assign w_short    = (r_len_eff <= c_one);
  assign w_food     = (r_head_x == r_food_x) && (r_head_y == r_food_y);
  assign w_last     = r_len_eff - c_one;
  assign w_match    = (bus.rd_x == r_head_x) && (bus.rd_y == r_head_y);
  assign w_stop     = (w_match && (EARLY_EXIT != 0)) || (r_cmp_idx == w_last);
  assign w_addr_inc = (r_rd_addr < w_last) ? (r_rd_addr + c_one) : r_rd_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_CHECK;
      S_CHECK:  w_next = (w_wall || w_short) ? S_FINISH : S_SCAN;
      S_SCAN:   if (w_stop) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand latch, read-address walk and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_x    <= '0;
      r_head_y    <= '0;
      r_food_x    <= '0;
      r_food_y    <= '0;
      r_len_eff   <= '0;
      r_rd_addr   <= '0;
      r_cmp_idx   <= '0;
      r_hit_self  <= 1'b0;
      r_hit_wall  <= 1'b0;
      r_hit_food  <= 1'b0;
      r_hit_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_head_x    <= bus.head_x;
            r_head_y    <= bus.head_y;
            r_food_x    <= bus.food_x;
            r_food_y    <= bus.food_y;
            r_len_eff   <= w_in_len_eff;
            r_hit_self  <= 1'b0;
            r_hit_wall  <= 1'b0;
            r_hit_food  <= 1'b0;
            r_hit_index <= '0;
            // Skipped checks leave the read port untouched
            if (!w_in_skip) r_rd_addr <= c_one;
          end
        end
        S_CHECK: begin
          r_hit_wall <= w_wall;
          r_hit_food <= w_food && !w_wall;
          r_cmp_idx  <= c_one;
          if (!w_wall && !w_short) r_rd_addr <= w_addr_inc;
        end
        S_SCAN: begin
          // Only the first match records its index
          if (w_match && !r_hit_self) begin
            r_hit_self  <= 1'b1;
            r_hit_index <= r_cmp_idx;
          end
          if (!w_stop) begin
            r_cmp_idx <= r_cmp_idx + c_one;
            r_rd_addr <= w_addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_addr   = r_rd_addr;
  assign bus.busy      = (r_state == S_CHECK) || (r_state == S_SCAN);
  assign bus.done      = (r_state == S_FINISH);
  assign bus.hit_self  = r_hit_self;
  assign bus.hit_wall  = r_hit_wall;
  assign bus.hit_food  = r_hit_food;
  assign bus.hit_index = r_hit_index;

endmodule
`default_nettype wire

// File: tb/tb_snake_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_collision_scanner
// Purpose  : Drives two scanner instances (16x16 grid with early exit, and a
//            12x10 grid with full scans) from one stimulus stream and checks
//            them against a behavioural model of the collision rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_collision_scanner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       t_start = 1'b0;
  logic [3:0] t_hx = '0, t_hy = '0, t_fx = '0, t_fy = '0;
  logic [7:0] t_len = '0;
  logic [3:0] bx [256];
  logic [3:0] by [256];

  int n_cmp = 0;
  int n_err = 0;

  snake_collision_scanner_if #(.COORD_W(4), .LEN_W(8)) ia ();
  snake_collision_scanner_if #(.COORD_W(4), .LEN_W(8)) ib ();

  snake_collision_scanner #(.COORD_W(4), .LEN_W(8), .MAX_LEN(128), .GRID_W(16),
                            .GRID_H(16), .EARLY_EXIT(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ia));
  snake_collision_scanner #(.COORD_W(4), .LEN_W(8), .MAX_LEN(128), .GRID_W(12),
                            .GRID_H(10), .EARLY_EXIT(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ib));

  assign ia.start = t_start;  assign ib.start = t_start;
  assign ia.head_x = t_hx;    assign ib.head_x = t_hx;
  assign ia.head_y = t_hy;    assign ib.head_y = t_hy;
  assign ia.food_x = t_fx;    assign ib.food_x = t_fx;
  assign ia.food_y = t_fy;    assign ib.food_y = t_fy;
  assign ia.snake_length = t_len;
  assign ib.snake_length = t_len;

  // Synchronous body store: data appears one cycle after the address
  always @(posedge clk) begin
    ia.rd_x <= bx[ia.rd_addr];
    ia.rd_y <= by[ia.rd_addr];
    ib.rd_x <= bx[ib.rd_addr];
    ib.rd_y <= by[ib.rd_addr];
  end

  bit s_done [2], s_busy [2], s_self [2], s_wall [2], s_food [2];
  int s_idx [2], s_addr [2];

  task automatic sample();
    s_done[0] = ia.done;     s_done[1] = ib.done;
    s_busy[0] = ia.busy;     s_busy[1] = ib.busy;
    s_self[0] = ia.hit_self; s_self[1] = ib.hit_self;
    s_wall[0] = ia.hit_wall; s_wall[1] = ib.hit_wall;
    s_food[0] = ia.hit_food; s_food[1] = ib.hit_food;
    s_idx[0]  = int'(ia.hit_index); s_idx[1]  = int'(ib.hit_index);
    s_addr[0] = int'(ia.rd_addr);   s_addr[1] = int'(ib.rd_addr);
  endtask

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic string dtag(input string tag, input int k);
    return $sformatf("%s_%s", tag, (k == 0) ? "A" : "B");
  endfunction

  // Collision rules evaluated directly on the current request and body array.
  // Latency counts the cycle in which done is seen, accept edge = cycle 0.
  // Reads go out one address per cycle from 1; the compare of index k occurs
  // while address k+1 is being issued, capped at the last valid index.
  function automatic void model(input int gw, input int gh, input int ml, input int ee,
                                output int lat, output int wall, output int food,
                                output int self_hit, output int idx, output int skip,
                                output int last_addr);
    int le;
    le        = (int'(t_len) > ml) ? ml : int'(t_len);
    wall      = (int'(t_hx) >= gw || int'(t_hy) >= gh) ? 1 : 0;
    food      = (t_hx == t_fx && t_hy == t_fy && wall == 0) ? 1 : 0;
    skip      = (wall == 1 || le <= 1) ? 1 : 0;
    self_hit  = 0;
    idx       = 0;
    if (skip == 0)
      for (int i = 1; i < le; i++)
        if (self_hit == 0 && bx[i] == t_hx && by[i] == t_hy) begin
          self_hit = 1;
          idx      = i;
        end
    if (skip == 1)                    lat = 2;
    else if (ee != 0 && self_hit == 1) lat = idx + 2;
    else                              lat = le + 1;
    if (skip == 1)                    last_addr = -1;
    else if (ee != 0 && self_hit == 1) last_addr = (idx + 1 < le - 1) ? idx + 1 : le - 1;
    else                              last_addr = le - 1;
  endfunction

  task automatic fill_body_nomatch();
    for (int i = 0; i < 256; i++) begin
      bx[i] = 4'($urandom_range(0, 15));
      by[i] = 4'($urandom_range(0, 15));
      if (bx[i] == t_hx && by[i] == t_hy) by[i] = t_hy + 4'd1;
    end
  endtask

  task automatic run_op(input string tag);
    int lat [2], wl [2], fd [2], sf [2], ix [2], sk [2], la [2], pre [2];
    bit seen [2], moved [2];
    model(16, 16, 128, 1, lat[0], wl[0], fd[0], sf[0], ix[0], sk[0], la[0]);
    model(12, 10, 128, 0, lat[1], wl[1], fd[1], sf[1], ix[1], sk[1], la[1]);
    sample();
    for (int k = 0; k < 2; k++) begin
      pre[k] = s_addr[k]; seen[k] = 0; moved[k] = 0;
    end
    @(negedge clk) t_start = 1'b1;
    @(posedge clk); #1 t_start = 1'b0;
    sample();
    for (int k = 0; k < 2; k++) check_eq(dtag({tag, "_busy"}, k), int'(s_busy[k]), 1);
    for (int cyc = 1; cyc <= 300 && !(seen[0] && seen[1]); cyc++) begin
      @(posedge clk); #1;
      sample();
      for (int k = 0; k < 2; k++) begin
        if (!seen[k]) begin
          if (s_addr[k] != pre[k]) moved[k] = 1;
          if (s_done[k]) begin
            seen[k] = 1;
            check_eq(dtag({tag, "_lat"}, k),   cyc + 1, lat[k]);
            check_eq(dtag({tag, "_wall"}, k),  int'(s_wall[k]), wl[k]);
            check_eq(dtag({tag, "_food"}, k),  int'(s_food[k]), fd[k]);
            check_eq(dtag({tag, "_self"}, k),  int'(s_self[k]), sf[k]);
            check_eq(dtag({tag, "_index"}, k), s_idx[k], ix[k]);
            check_eq(dtag({tag, "_busy0"}, k), int'(s_busy[k]), 0);
            if (sk[k] == 1) check_eq(dtag({tag, "_noread"}, k), int'(moved[k]), 0);
            else            check_eq(dtag({tag, "_lastaddr"}, k), s_addr[k], la[k]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++)
      if (!seen[k]) check_eq(dtag({tag, "_timeout"}, k), 0, 1);
    @(posedge clk); #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      check_eq(dtag({tag, "_pulse"}, k), int'(s_done[k]), 0);
      check_eq(dtag({tag, "_hold"}, k),  s_idx[k], ix[k]);
    end
  endtask

  function automatic int out_sum(input int k);
    return int'(s_busy[k]) + int'(s_done[k]) + int'(s_self[k]) + int'(s_wall[k]) +
           int'(s_food[k]) + s_idx[k] + s_addr[k];
  endfunction

  initial begin
    int dcnt [2];
    int dpos [2][2];
    int la, wl, fd, sf, ix, sk, lad;
    int lat3;

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 sample();
    for (int k = 0; k < 2; k++) check_eq(dtag("reset_out", k), out_sum(k), 0);
    @(negedge clk) rst = 1'b0;

    // Self hit at index 1
    t_hx = 4'd5; t_hy = 4'd5; t_fx = 4'd0; t_fy = 4'd0; t_len = 8'd3;
    fill_body_nomatch();
    bx[1] = 4'd5; by[1] = 4'd5; bx[2] = 4'd4; by[2] = 4'd4;
    run_op("selfhit");

    // No hit, full scan
    bx[1] = 4'd4; by[1] = 4'd4; bx[2] = 4'd3; by[2] = 4'd3;
    run_op("nohit");

    // Wall on the 12-wide grid, then just inside it
    t_hx = 4'd12; t_hy = 4'd3;
    run_op("wall12");
    t_hx = 4'd11;
    run_op("wall11");

    // Food hit with length clamp and two body matches
    t_hx = 4'd7; t_hy = 4'd2; t_fx = 4'd7; t_fy = 4'd2; t_len = 8'd200;
    fill_body_nomatch();
    bx[50] = 4'd7; by[50] = 4'd2; bx[90] = 4'd7; by[90] = 4'd2;
    run_op("clamp");

    // Length one: nothing to scan
    t_len = 8'd1;
    run_op("len1");

    // Start held high: one scan per IDLE acceptance, single-cycle done pulses
    t_hx = 4'd5; t_hy = 4'd5; t_fx = 4'd1; t_fy = 4'd1; t_len = 8'd3;
    fill_body_nomatch();
    model(16, 16, 128, 1, lat3, wl, fd, sf, ix, sk, lad);
    for (int k = 0; k < 2; k++) begin
      dcnt[k] = 0; dpos[k][0] = -1; dpos[k][1] = -1;
    end
    @(negedge clk) t_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 2 * lat3 + 1; cyc++) begin
      @(posedge clk); #1;
      sample();
      for (int k = 0; k < 2; k++)
        if (s_done[k]) begin
          if (dcnt[k] < 2) dpos[k][dcnt[k]] = cyc + 1;
          dcnt[k]++;
        end
    end
    @(negedge clk) t_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_eq(dtag("held_count", k), dcnt[k], 2);
      check_eq(dtag("held_first", k), dpos[k][0], lat3);
      check_eq(dtag("held_second", k), dpos[k][1], 2 * lat3 + 1);
    end
    repeat (lat3 + 2) @(posedge clk);

    // Reset in the middle of a 100-long scan
    t_len = 8'd100;
    fill_body_nomatch();
    @(negedge clk) t_start = 1'b1;
    @(posedge clk); #1 t_start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 sample();
    for (int k = 0; k < 2; k++) check_eq(dtag("midreset_out", k), out_sum(k), 0);
    for (int k = 0; k < 2; k++) dcnt[k] = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 2) rst = 1'b0;
      @(posedge clk); #1;
      sample();
      for (int k = 0; k < 2; k++) if (s_done[k]) dcnt[k]++;
    end
    for (int k = 0; k < 2; k++) check_eq(dtag("midreset_nodone", k), dcnt[k], 0);
    run_op("afterreset");

    // Randomized requests
    for (int n = 0; n < 30; n++) begin
      int j;
      t_hx  = 4'($urandom_range(0, 15));
      t_hy  = 4'($urandom_range(0, 15));
      t_len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(2, 255));
      if ($urandom_range(0, 1) == 1) begin
        t_fx = t_hx; t_fy = t_hy;
      end else begin
        t_fx = 4'($urandom_range(0, 15)); t_fy = 4'($urandom_range(0, 15));
      end
      for (int i = 0; i < 256; i++) begin
        bx[i] = 4'($urandom_range(0, 15));
        by[i] = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 1 && t_len > 8'd2) begin
        j = $urandom_range(1, int'(t_len) - 1);
        bx[j] = t_hx; by[j] = t_hy;
      end
      run_op("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
